// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: shares one simple dual-port RAM between NUM_REQ clients.
// The write and read ports each have an independent round-robin arbiter.
// Each granted read is tagged with the issuing requester's index. The
// returned data and valid are routed back to that requester one cycle later.
module mem_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        rq_wr_vld_i,
  input  logic [NUM_REQ*ADDR_W-1:0] rq_wr_addr_i,
  input  logic [NUM_REQ*DATA_W-1:0] rq_wr_data_i,
  output logic [NUM_REQ-1:0]        rq_wr_rdy_o,
  input  logic [NUM_REQ-1:0]        rq_rd_vld_i,
  input  logic [NUM_REQ*ADDR_W-1:0] rq_rd_addr_i,
  output logic [NUM_REQ-1:0]        rq_rd_rdy_o,
  output logic [NUM_REQ-1:0]        rq_rsp_vld_o,
  output logic [DATA_W-1:0]         rq_rsp_data_o,
  output logic                      m_wr_vld_o,
  output logic [ADDR_W-1:0]         m_wr_addr_o,
  output logic [DATA_W-1:0]         m_wr_data_o,
  input  logic                      m_wr_rdy_i,
  output logic                      m_rd_vld_o,
  output logic [ADDR_W-1:0]         m_rd_addr_o,
  input  logic [DATA_W-1:0]         m_rd_data_i,
  input  logic                      m_rd_rdy_i
);

  localparam int ID_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

  // First requester at or after ptr (wrapping) with its valid bit set.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                              input logic [ID_W-1:0]    ptr);
    logic [ID_W-1:0] pick;
    logic            found;
    int              idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && vld[idx[ID_W-1:0]]) begin
        pick  = idx[ID_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Pointer value just past the winner, wrapping at NUM_REQ.
  function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] w);
    return (int'(w) == NUM_REQ - 1) ? '0 : w + 1'b1;
  endfunction

  logic [ID_W-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [ID_W-1:0]   rd_ptr_reg, rd_ptr_next;
  logic              tag_vld_reg;
  logic [ID_W-1:0]   tag_id_reg;

  logic              wr_any, rd_any;
  logic [ID_W-1:0]   wr_win, rd_win;

  logic [ADDR_W-1:0] wr_addr_arr [NUM_REQ];
  logic [DATA_W-1:0] wr_data_arr [NUM_REQ];
  logic [ADDR_W-1:0] rd_addr_arr [NUM_REQ];

  // Unpack the flat request buses and build the one-hot per-requester strobes.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign wr_addr_arr[gi]  = rq_wr_addr_i[gi*ADDR_W +: ADDR_W];
    assign wr_data_arr[gi]  = rq_wr_data_i[gi*DATA_W +: DATA_W];
    assign rd_addr_arr[gi]  = rq_rd_addr_i[gi*ADDR_W +: ADDR_W];
    assign rq_wr_rdy_o[gi]  = wr_any & m_wr_rdy_i & (wr_win == ID_W'(gi));
    assign rq_rd_rdy_o[gi]  = rd_any & (rd_win == ID_W'(gi));
    // A read-valid from memory with no outstanding tag is silently dropped.
    assign rq_rsp_vld_o[gi] = tag_vld_reg & m_rd_rdy_i & (tag_id_reg == ID_W'(gi));
  end

  assign wr_any      = |rq_wr_vld_i;
  assign rd_any      = |rq_rd_vld_i;
  assign wr_win      = rr_pick(rq_wr_vld_i, wr_ptr_reg);
  assign rd_win      = rr_pick(rq_rd_vld_i, rd_ptr_reg);
  assign wr_ptr_next = rr_next(wr_win);
  assign rd_ptr_next = rr_next(rd_win);

  assign m_wr_vld_o    = wr_any;
  assign m_wr_addr_o   = wr_any ? wr_addr_arr[wr_win] : '0;
  assign m_wr_data_o   = wr_any ? wr_data_arr[wr_win] : '0;
  assign m_rd_vld_o    = rd_any;
  assign m_rd_addr_o   = rd_any ? rd_addr_arr[rd_win] : '0;
  assign rq_rsp_data_o = m_rd_data_i;

  // Write pointer advances only on a completed memory write handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
    end else if (wr_any && m_wr_rdy_i) begin
      wr_ptr_reg <= wr_ptr_next;
    end
  end

  // Read pointer advances on every grant; the read port never stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_reg <= '0;
    end else if (rd_any) begin
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  // Tag register tracks who owns the data the memory returns next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_reg <= 1'b0;
      tag_id_reg  <= '0;
    end else begin
      tag_vld_reg <= rd_any;
      if (rd_any) begin
        tag_id_reg <= rd_win;
      end
    end
  end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb_mem_rr_arbiter: directed vector table, hand-written corner sequences and
// random traffic for mem_rr_arbiter. A behavioural RAM sits behind the DUT,
// and a reference model follows the arbitration rules every cycle.
module tb_mem_rr_arbiter;
  localparam int N = 4;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  rq_wr_vld_i;
  logic [4*8-1:0] rq_wr_addr_i;
  logic [4*8-1:0] rq_wr_data_i;
  logic [N-1:0]  rq_wr_rdy_o;
  logic [N-1:0]  rq_rd_vld_i;
  logic [4*8-1:0] rq_rd_addr_i;
  logic [N-1:0]  rq_rd_rdy_o;
  logic [N-1:0]  rq_rsp_vld_o;
  logic [7:0]    rq_rsp_data_o;
  logic          m_wr_vld_o;
  logic [7:0]    m_wr_addr_o;
  logic [7:0]    m_wr_data_o;
  logic          m_wr_rdy_i;
  logic          m_rd_vld_o;
  logic [7:0]    m_rd_addr_o;
  logic [7:0]    m_rd_data_i;
  logic          m_rd_rdy_i;

  int checks = 0;
  int errors = 0;

  // Behavioural RAM: write at the edge, registered read with valid pulse.
  logic [7:0] ram [256] = '{default: 8'h00};
  logic [7:0] ram_rdata = 8'h00;
  logic       ram_rvld  = 1'b0;
  logic       force_rrdy;

  assign m_rd_data_i = ram_rdata;
  assign m_rd_rdy_i  = ram_rvld | force_rrdy;

  mem_rr_arbiter #(.NUM_REQ(N), .DATA_W(8), .ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .rq_wr_vld_i(rq_wr_vld_i), .rq_wr_addr_i(rq_wr_addr_i),
    .rq_wr_data_i(rq_wr_data_i), .rq_wr_rdy_o(rq_wr_rdy_o),
    .rq_rd_vld_i(rq_rd_vld_i), .rq_rd_addr_i(rq_rd_addr_i),
    .rq_rd_rdy_o(rq_rd_rdy_o), .rq_rsp_vld_o(rq_rsp_vld_o),
    .rq_rsp_data_o(rq_rsp_data_o),
    .m_wr_vld_o(m_wr_vld_o), .m_wr_addr_o(m_wr_addr_o),
    .m_wr_data_o(m_wr_data_o), .m_wr_rdy_i(m_wr_rdy_i),
    .m_rd_vld_o(m_rd_vld_o), .m_rd_addr_o(m_rd_addr_o),
    .m_rd_data_i(m_rd_data_i), .m_rd_rdy_i(m_rd_rdy_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model behind the memory-side ports.
  always @(posedge clk) begin
    if (m_wr_vld_o && m_wr_rdy_i) ram[m_wr_addr_o] <= m_wr_data_o;
    ram_rvld <= m_rd_vld_o;
    if (m_rd_vld_o) ram_rdata <= ram[m_rd_addr_o];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arbitration: scan ptr, ptr+1, ... modulo N for a set request.
  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] r;
    r = '0;
    if (i >= 0) r[i] = 1'b1;
    return r;
  endfunction

  // Reference model: checks every cycle at the falling edge, advances at the rising edge.
  int         m_wptr, m_rptr, m_pid, s_ew, s_er;
  bit         m_pend, s_rst, s_wrdy;
  logic [7:0] m_pdata, s_waddr, s_wdata, s_raddr;
  logic [7:0] shadow [256];
  initial begin
    m_wptr = 0; m_rptr = 0; m_pend = 0; m_pid = 0; m_pdata = 8'h00;
    for (int a = 0; a < 256; a++) shadow[a] = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_wptr = 0; m_rptr = 0; m_pend = 0;
      end
      s_ew = pick(rq_wr_vld_i, m_wptr);
      s_er = pick(rq_rd_vld_i, m_rptr);
      s_wrdy = m_wr_rdy_i; s_rst = rst_n;
      s_waddr = (s_ew >= 0) ? rq_wr_addr_i[s_ew*8 +: 8] : 8'h00;
      s_wdata = (s_ew >= 0) ? rq_wr_data_i[s_ew*8 +: 8] : 8'h00;
      s_raddr = (s_er >= 0) ? rq_rd_addr_i[s_er*8 +: 8] : 8'h00;
      chk("mdl_wr_rdy", rq_wr_rdy_o, s_wrdy ? onehot(s_ew) : '0);
      chk("mdl_m_wr_vld", m_wr_vld_o, s_ew >= 0);
      chk("mdl_m_wr_addr", m_wr_addr_o, s_waddr);
      chk("mdl_m_wr_data", m_wr_data_o, s_wdata);
      chk("mdl_rd_rdy", rq_rd_rdy_o, onehot(s_er));
      chk("mdl_m_rd_vld", m_rd_vld_o, s_er >= 0);
      chk("mdl_m_rd_addr", m_rd_addr_o, s_raddr);
      chk("mdl_rsp_vld", rq_rsp_vld_o, (m_pend && m_rd_rdy_i) ? onehot(m_pid) : '0);
      if (m_pend && m_rd_rdy_i) chk("mdl_rsp_data", rq_rsp_data_o, m_pdata);
      @(posedge clk);
      if (s_rst) begin
        if (s_er >= 0) begin
          m_pend = 1; m_pid = s_er; m_pdata = shadow[s_raddr];
          m_rptr = (s_er + 1) % N;
        end else begin
          m_pend = 0;
        end
        if (s_ew >= 0 && s_wrdy) begin
          shadow[s_waddr] = s_wdata;
          m_wptr = (s_ew + 1) % N;
        end
      end
    end
  end

  typedef struct {
    logic          rst;
    logic [N-1:0]  wv;
    logic [31:0]   wa;
    logic [31:0]   wd;
    logic          wrdy;
    logic [N-1:0]  rv;
    logic [31:0]   ra;
    logic [N-1:0]  e_wrdy;
    logic [N-1:0]  e_rrdy;
    logic [N-1:0]  e_rsp;
    logic [7:0]    e_data;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic [3:0] wv, input logic [31:0] wa,
                              input logic [31:0] wd, input logic wrdy, input logic [3:0] rv,
                              input logic [31:0] ra, input logic [3:0] e_wrdy,
                              input logic [3:0] e_rrdy, input logic [3:0] e_rsp,
                              input logic [7:0] e_data);
    vec_t v;
    v.rst = rst; v.wv = wv; v.wa = wa; v.wd = wd; v.wrdy = wrdy; v.rv = rv; v.ra = ra;
    v.e_wrdy = e_wrdy; v.e_rrdy = e_rrdy; v.e_rsp = e_rsp; v.e_data = e_data;
    return v;
  endfunction

  task automatic drive(input logic rst_lvl_n, input logic [3:0] wv, input logic [31:0] wa,
                       input logic [31:0] wd, input logic wrdy, input logic [3:0] rv,
                       input logic [31:0] ra);
    rst_n = rst_lvl_n; rq_wr_vld_i = wv; rq_wr_addr_i = wa; rq_wr_data_i = wd;
    m_wr_rdy_i = wrdy; rq_rd_vld_i = rv; rq_rd_addr_i = ra;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [19];

  initial begin
    // Directed table: single write/read, reset, write RR, preload, read RR.
    tbl[0]  = mk(0, 4'b0100, 32'h0010_0000, 32'h00A5_0000, 1, 4'b0000, 32'h0, 4'b0100, 4'b0000, 4'b0000, 8'h00);
    tbl[1]  = mk(0, 4'b0000, 32'h0, 32'h0, 1, 4'b0100, 32'h0010_0000, 4'b0000, 4'b0100, 4'b0000, 8'h00);
    tbl[2]  = mk(0, 4'b0000, 32'h0, 32'h0, 1, 4'b0000, 32'h0, 4'b0000, 4'b0000, 4'b0100, 8'hA5);
    tbl[3]  = mk(1, 4'b0000, 32'h0, 32'h0, 1, 4'b0000, 32'h0, 4'b0000, 4'b0000, 4'b0000, 8'h00);
    for (int i = 0; i < 8; i++)
      tbl[4+i] = mk(0, 4'b1111, 32'h4342_4140, 32'hC3C2_C1C0, 1, 4'b0000, 32'h0,
                    onehot(i % 4), 4'b0000, 4'b0000, 8'h00);
    tbl[12] = mk(0, 4'b0010, 32'h0000_0100, 32'h0000_1100, 1, 4'b0000, 32'h0, 4'b0010, 4'b0000, 4'b0000, 8'h00);
    tbl[13] = mk(0, 4'b1000, 32'h0300_0000, 32'h3300_0000, 1, 4'b0000, 32'h0, 4'b1000, 4'b0000, 4'b0000, 8'h00);
    tbl[14] = mk(0, 4'b0000, 32'h0, 32'h0, 1, 4'b1010, 32'h0300_0100, 4'b0000, 4'b0010, 4'b0000, 8'h00);
    tbl[15] = mk(0, 4'b0000, 32'h0, 32'h0, 1, 4'b1010, 32'h0300_0100, 4'b0000, 4'b1000, 4'b0010, 8'h11);
    tbl[16] = mk(0, 4'b0000, 32'h0, 32'h0, 1, 4'b1010, 32'h0300_0100, 4'b0000, 4'b0010, 4'b1000, 8'h33);
    tbl[17] = mk(0, 4'b0000, 32'h0, 32'h0, 1, 4'b1010, 32'h0300_0100, 4'b0000, 4'b1000, 4'b0010, 8'h11);
    tbl[18] = mk(0, 4'b0000, 32'h0, 32'h0, 1, 4'b0000, 32'h0, 4'b0000, 4'b0000, 4'b1000, 8'h33);

    force_rrdy = 1'b0;
    drive(1'b0, 4'b0, 32'h0, 32'h0, 1'b1, 4'b0, 32'h0);
    @(negedge clk);
    chk("reset_rsp_vld", rq_rsp_vld_o, 4'b0000);
    chk("reset_wr_rdy", rq_wr_rdy_o, 4'b0000);
    chk("reset_rd_rdy", rq_rd_rdy_o, 4'b0000);
    next_cycle();
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      drive(!tbl[i].rst, tbl[i].wv, tbl[i].wa, tbl[i].wd, tbl[i].wrdy, tbl[i].rv, tbl[i].ra);
      @(negedge clk);
      chk($sformatf("vec%0d_wr_rdy", i), rq_wr_rdy_o, tbl[i].e_wrdy);
      chk($sformatf("vec%0d_rd_rdy", i), rq_rd_rdy_o, tbl[i].e_rrdy);
      chk($sformatf("vec%0d_rsp_vld", i), rq_rsp_vld_o, tbl[i].e_rsp);
      if (tbl[i].e_rsp != 4'b0000)
        chk($sformatf("vec%0d_rsp_data", i), rq_rsp_data_o, tbl[i].e_data);
      $display("vec %0d wr_rdy=%b rd_rdy=%b rsp_vld=%b rsp_data=%h",
               i, rq_wr_rdy_o, rq_rd_rdy_o, rq_rsp_vld_o, rq_rsp_data_o);
      next_cycle();
    end

    // Memory holds each requester's round-robin write.
    for (int i = 0; i < 4; i++) begin
      logic [7:0] exp_d;
      exp_d = 8'hC0 + 8'(i);
      chk($sformatf("ram_rr_%0d", i), ram[8'h40 + 8'(i)], exp_d);
    end

    // Memory read-valid with no tag pending is dropped.
    drive(1'b1, 4'b0, 32'h0, 32'h0, 1'b1, 4'b0, 32'h0);
    force_rrdy = 1'b1;
    @(negedge clk);
    chk("orphan_rsp_vld", rq_rsp_vld_o, 4'b0000);
    $display("orphan rsp_vld=%b", rq_rsp_vld_o);
    next_cycle();
    force_rrdy = 1'b0;

    // Write backpressure: no grant and winner stays req 0 while stalled.
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 4'b0011, 32'h0000_5150, 32'h0000_0201, 1'b0, 4'b0, 32'h0);
      @(negedge clk);
      chk("bp_wr_rdy", rq_wr_rdy_o, 4'b0000);
      chk("bp_wr_addr", m_wr_addr_o, 8'h50);
      $display("bp stall %0d wr_rdy=%b addr=%h", c, rq_wr_rdy_o, m_wr_addr_o);
      next_cycle();
    end
    drive(1'b1, 4'b0011, 32'h0000_5150, 32'h0000_0201, 1'b1, 4'b0, 32'h0);
    @(negedge clk);
    chk("bp_release_req0", rq_wr_rdy_o, 4'b0001);
    chk("bp_release_data", m_wr_data_o, 8'h01);
    $display("bp release wr_rdy=%b", rq_wr_rdy_o);
    next_cycle();
    drive(1'b1, 4'b0010, 32'h0000_5150, 32'h0000_0201, 1'b1, 4'b0, 32'h0);
    @(negedge clk);
    chk("bp_then_req1", rq_wr_rdy_o, 4'b0010);
    $display("bp next wr_rdy=%b", rq_wr_rdy_o);
    next_cycle();

    // Same-cycle write and read of 0x20: old data first, new data after.
    drive(1'b1, 4'b0001, 32'h0000_0020, 32'h0000_005A, 1'b1, 4'b0010, 32'h0000_2000);
    @(negedge clk);
    chk("coll_wr_rdy", rq_wr_rdy_o, 4'b0001);
    chk("coll_rd_rdy", rq_rd_rdy_o, 4'b0010);
    next_cycle();
    drive(1'b1, 4'b0000, 32'h0, 32'h0, 1'b1, 4'b0010, 32'h0000_2000);
    @(negedge clk);
    chk("coll_old_vld", rq_rsp_vld_o, 4'b0010);
    chk("coll_old_data", rq_rsp_data_o, 8'h00);
    $display("collision old rsp_vld=%b data=%h", rq_rsp_vld_o, rq_rsp_data_o);
    next_cycle();
    drive(1'b1, 4'b0000, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0);
    @(negedge clk);
    chk("coll_new_vld", rq_rsp_vld_o, 4'b0010);
    chk("coll_new_data", rq_rsp_data_o, 8'h5A);
    $display("collision new rsp_vld=%b data=%h", rq_rsp_vld_o, rq_rsp_data_o);
    next_cycle();

    // Reset in the cycle after a read grant suppresses the response.
    drive(1'b1, 4'b0000, 32'h0, 32'h0, 1'b1, 4'b0100, 32'h0010_0000);
    @(negedge clk);
    chk("rstmid_grant", rq_rd_rdy_o, 4'b0100);
    next_cycle();
    drive(1'b0, 4'b0000, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0);
    @(negedge clk);
    chk("rstmid_mem_rvld", m_rd_rdy_i, 1'b1);
    chk("rstmid_rsp_vld", rq_rsp_vld_o, 4'b0000);
    $display("reset mid-read rsp_vld=%b", rq_rsp_vld_o);
    next_cycle();
    next_cycle();
    drive(1'b1, 4'b0000, 32'h0, 32'h0, 1'b1, 4'b1111, 32'h0302_0100);
    @(negedge clk);
    chk("rstmid_first_rd", rq_rd_rdy_o, 4'b0001);
    $display("after reset rd_rdy=%b", rq_rd_rdy_o);
    next_cycle();

    // Random traffic; the reference model checks every cycle.
    for (int c = 0; c < 400; c++) begin
      logic [31:0] wa, wd, ra;
      for (int r = 0; r < 4; r++) begin
        wa[r*8 +: 8] = 8'($urandom_range(0, 15));
        wd[r*8 +: 8] = 8'($urandom);
        ra[r*8 +: 8] = 8'($urandom_range(0, 15));
      end
      drive(1'b1, 4'($urandom), wa, wd, 1'($urandom_range(0, 3) != 0), 4'($urandom), ra);
      force_rrdy = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      $display("rnd %0d wv=%b rv=%b wr_rdy=%b rd_rdy=%b rsp=%b data=%h",
               c, rq_wr_vld_i, rq_rd_vld_i, rq_wr_rdy_o, rq_rd_rdy_o, rq_rsp_vld_o, rq_rsp_data_o);
      next_cycle();
    end
    force_rrdy = 1'b0;
    drive(1'b1, 4'b0, 32'h0, 32'h0, 1'b1, 4'b0, 32'h0);
    next_cycle();
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_rr_arbiter.md
Name: mem_rr_arbiter

Overview:
- Shares one simple dual-port RAM (independent write and read ports; registered read data returned 1 cycle after the read request, with a read-valid pulse) between NUM_REQ requesters.
- Runs two independent round-robin arbiters, one for the write port and one for the read port.
- Tags each granted read and routes the returned data/valid back to the issuing requester.
- Sits between the client blocks and the memory instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_W, 8, data width; matches the memory.
- ADDR_W, 8, address width; matches the memory.
- ID_W, $clog2(NUM_REQ) (min 1), local, requester index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- rq_wr_vld_i  in  NUM_REQ  per-requester write request
- rq_wr_addr_i  in  NUM_REQ*ADDR_W  packed write addresses; requester i at [i*ADDR_W +: ADDR_W]
- rq_wr_data_i  in  NUM_REQ*DATA_W  packed write data
- rq_wr_rdy_o  out  NUM_REQ  write accepted this cycle (one-hot or zero)
- rq_rd_vld_i  in  NUM_REQ  per-requester read request
- rq_rd_addr_i  in  NUM_REQ*ADDR_W  packed read addresses
- rq_rd_rdy_o  out  NUM_REQ  read accepted this cycle (one-hot or zero)
- rq_rsp_vld_o  out  NUM_REQ  read data valid for requester i (one-hot or zero)
- rq_rsp_data_o  out  DATA_W  read data, shared by all requesters; qualified by rq_rsp_vld_o
- m_wr_vld_o  out  1  memory write valid
- m_wr_addr_o  out  ADDR_W  memory write address
- m_wr_data_o  out  DATA_W  memory write data
- m_wr_rdy_i  in  1  memory write ready
- m_rd_vld_o  out  1  memory read valid
- m_rd_addr_o  out  ADDR_W  memory read address
- m_rd_data_i  in  DATA_W  memory read data
- m_rd_rdy_i  in  1  memory read-data valid; arrives 1 cycle after m_rd_vld_o

Behaviour:
- Reset: wr_ptr = 0, rd_ptr = 0, tag_vld = 0, tag_id = 0.
  - Because tag_vld = 0, all rq_rsp_vld_o = 0.
  - Combinational outputs follow their inputs, so with all vld low every rdy/vld output is 0.
- Write grant (combinational):
  - Scan i = wr_ptr, wr_ptr+1, ... modulo NUM_REQ.
  - The first requester with rq_wr_vld_i[i] = 1 is the winner w.
  - m_wr_vld_o = any write request. m_wr_addr_o and m_wr_data_o = fields of w; 0 when there is no request.
  - rq_wr_rdy_o[w] = m_wr_rdy_i; all other bits are 0.
- Write pointer: on a handshake (m_wr_vld_o & m_wr_rdy_i), wr_ptr <= (w+1) mod NUM_REQ. Otherwise it holds.
  - If m_wr_rdy_i is low, the pointer does not move and the same winner is re-evaluated next cycle.
- Read grant: same scheme with rd_ptr and rq_rd_vld_i.
  - m_rd_vld_o = any read request; rq_rd_rdy_o[r] = 1 (the read port is always ready).
  - On a grant, rd_ptr <= (r+1) mod NUM_REQ.
- Read tag pipeline, registered every cycle:
  - tag_vld <= m_rd_vld_o
  - tag_id <= r when m_rd_vld_o is high
- Response routing:
  - rq_rsp_vld_o[tag_id] = tag_vld & m_rd_rdy_i; all other bits 0.
  - rq_rsp_data_o = m_rd_data_i (pass-through).
  - m_rd_rdy_i high while tag_vld = 0 is dropped; no response is asserted.
- Latency:
  - Write: 0 cycles to grant; the memory updates at the grant edge.
  - Read: rq_rd_rdy_o in cycle T, then rq_rsp_vld_o in cycle T+1.
  - Back-to-back reads are supported every cycle, since the tag register reloads every cycle.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 grants on a channel. The write and read arbiters are fully independent.
- Same-cycle read and write to the same address: the memory returns the old data; the arbiter does no forwarding.
- Requester contract: a requester holds vld/addr/data stable until it sees rdy. The arbiter does not latch requests.
- Reset mid-operation: a pending tag is cleared, so an in-flight response is suppressed. Pointers return to 0.

Test Plan:
- Single write then read: req 2 writes addr 0x10 / data 0xA5 (rq_wr_rdy_o = 4'b0100 same cycle). Req 2 then reads 0x10 → rq_rsp_vld_o = 4'b0100 next cycle with data 0xA5.
- Write round-robin: all 4 requesters hold rq_wr_vld_i for 8 cycles → grants in order 0,1,2,3,0,1,2,3. Memory contents equal each requester's data at its address.
- Read round-robin with back-to-back responses: requesters 1 and 3 read continuously (addr 0x01 and 0x03, preloaded 0x11 and 0x33). Grants alternate 1,3,1,3. Responses arrive one cycle later, alternating 4'b0010 / 4'b1000 with data 0x11 / 0x33.
- Write backpressure: m_wr_rdy_i = 0 for 3 cycles while req 0 and req 1 request → no rq_wr_rdy_o and wr_ptr stays 0. When m_wr_rdy_i rises, req 0 is granted, then req 1.
- Read/write collision: same-cycle write of 0x5A and read of addr 0x20, which holds 0x00 → response data 0x00. A read one cycle later returns 0x5A.
- Reset mid-read: assert rst_n low in the cycle after a read grant → rq_rsp_vld_o stays 0. After release, the first read grant goes to requester 0.
